// File: rtl/fp_align_pipe.sv
// FP adder alignment: magnitude ordering, implicit-bit restore, small-operand
// right shift with guard/round/sticky, two registered stages with valid/ready.
module fp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign_a,
  input  logic             in_sign_b,
  input  logic [EXP_W-1:0] in_exp_a,
  input  logic [EXP_W-1:0] in_exp_b,
  input  logic [MAN_W-1:0] in_man_a,
  input  logic [MAN_W-1:0] in_man_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_sign_big,
  output logic             out_sign_small,
  output logic [MAN_W:0]   out_man_big,
  output logic [MAN_W:0]   out_man_small,
  output logic             out_guard,
  output logic             out_round,
  output logic             out_sticky,
  output logic             out_swapped,
  output logic [EXP_W-1:0] out_diff
);

  localparam int SW = MAN_W + 3;
  localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(SW);
  localparam logic [EXP_W-1:0] ONE = EXP_W'(1);

  logic s1_valid;
  logic s2_valid;
  logic adv1;
  logic adv2;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  logic [EXP_W-1:0] eff_a;
  logic [EXP_W-1:0] eff_b;
  logic             imp_a;
  logic             imp_b;
  logic             b_big;

  assign imp_a = (in_exp_a != '0);
  assign imp_b = (in_exp_b != '0);
  assign eff_a = imp_a ? in_exp_a : ONE;
  assign eff_b = imp_b ? in_exp_b : ONE;
  // Equal magnitudes keep A as the big operand.
  assign b_big = {eff_b, imp_b, in_man_b} > {eff_a, imp_a, in_man_a};

  logic [EXP_W-1:0] s1_exp;
  logic [EXP_W-1:0] s1_diff;
  logic             s1_sign_big;
  logic             s1_sign_small;
  logic [MAN_W:0]   s1_man_big;
  logic [MAN_W:0]   s1_man_small;
  logic             s1_swapped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (adv2) s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_exp        <= '0;
      s1_diff       <= '0;
      s1_sign_big   <= 1'b0;
      s1_sign_small <= 1'b0;
      s1_man_big    <= '0;
      s1_man_small  <= '0;
      s1_swapped    <= 1'b0;
    end else if (adv1 && in_valid) begin
      s1_swapped <= b_big;
      if (b_big) begin
        s1_exp        <= eff_b;
        s1_diff       <= eff_b - eff_a;
        s1_sign_big   <= in_sign_b;
        s1_sign_small <= in_sign_a;
        s1_man_big    <= {imp_b, in_man_b};
        s1_man_small  <= {imp_a, in_man_a};
      end else begin
        s1_exp        <= eff_a;
        s1_diff       <= eff_a - eff_b;
        s1_sign_big   <= in_sign_a;
        s1_sign_small <= in_sign_b;
        s1_man_big    <= {imp_a, in_man_a};
        s1_man_small  <= {imp_b, in_man_b};
      end
    end
  end

  logic [EXP_W-1:0] sh;
  logic [SW-1:0]    ext;
  logic [SW-1:0]    shifted;
  logic [SW-1:0]    lost;

  assign sh      = (s1_diff >= SH_MAX) ? SH_MAX : s1_diff;
  assign ext     = {s1_man_small, 2'b00};
  assign shifted = ext >> sh;
  // Bits that fell below the round position feed sticky.
  assign lost    = ext & ~({SW{1'b1}} << sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_exp        <= '0;
      out_sign_big   <= 1'b0;
      out_sign_small <= 1'b0;
      out_man_big    <= '0;
      out_man_small  <= '0;
      out_guard      <= 1'b0;
      out_round      <= 1'b0;
      out_sticky     <= 1'b0;
      out_swapped    <= 1'b0;
      out_diff       <= '0;
    end else if (adv2 && s1_valid) begin
      out_exp        <= s1_exp;
      out_sign_big   <= s1_sign_big;
      out_sign_small <= s1_sign_small;
      out_man_big    <= s1_man_big;
      out_man_small  <= shifted[SW-1:2];
      out_guard      <= shifted[1];
      out_round      <= shifted[0];
      out_sticky     <= |lost;
      out_swapped    <= s1_swapped;
      out_diff       <= s1_diff;
    end
  end

endmodule
